// File: rtl/mix_bytes_iter.sv
// -----------------------------------------------------------------------------
// mix_bytes_iter
//
// Groestl MixBytes engine with the work spread over several cycles. Each
// 64-bit column of the state is multiplied by the circulant matrix
// B = circ(02,02,03,04,05,03,05,07) over GF(2^8) (poly 0x11B). LANES columns
// are mixed per cycle, so one full state takes STEPS = COLS/LANES cycles.
//
// The first LANES columns are mixed directly from the input bus in the accept
// cycle. This is what makes "accept at t -> out_valid at t+STEPS" hold for every
// STEPS, and it lets STEPS==1 go straight from accept to DONE. After the accept
// cycle, col points at the next unmixed column group.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous reset, active-high, priority over handshakes
//   in_valid   in   1   input state valid
//   in_ready   out  1   block can accept input (IDLE, or DONE with out_ready)
//   in         in   W   input state, column j = in[W-1-64j -: 64], byte 0 = MSB
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   downstream accepts result
//   out        out  W   result state, same packing as in
//   busy       out  1   high in BUSY or DONE
// -----------------------------------------------------------------------------
module mix_bytes_iter #(
    parameter int COLS  = 16,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [64*COLS-1:0]   in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [64*COLS-1:0]   out,
    output logic                 busy
);

    localparam int W     = 64 * COLS;
    localparam int STEPS = COLS / LANES;
    localparam int COL_W = $clog2(COLS);

    // Column index of the last group; reaching it in BUSY ends the operation,
    // so col never has to wrap.
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - LANES);
    localparam logic [COL_W-1:0] LANE_INC = COL_W'(LANES);

    // Matrix coefficients c[0..7], three bits each, c[0] in the top bits.
    localparam logic [23:0] MIX_COEF = {3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd5, 3'd7};

    generate
        if (!(COLS == 8 || COLS == 16)) begin : g_bad_cols
            $error("mix_bytes_iter: COLS must be 8 or 16");
        end
        if (LANES < 1 || LANES > COLS || (COLS % LANES) != 0) begin : g_bad_lanes
            $error("mix_bytes_iter: LANES must divide COLS");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // With a single step, the accept cycle already mixes every column.
    localparam state_t ACC_NXT = (STEPS == 1) ? ST_DONE : ST_BUSY;

    // ------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a coefficient below 8 by summing b, 2b and 4b as selected.
    function automatic logic [7:0] gf_mul_small(input logic [7:0] b, input logic [2:0] c);
        logic [7:0] b2;
        logic [7:0] b4;
        b2 = xtime(b);
        b4 = xtime(b2);
        return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[2] ? b4 : 8'h00);
    endfunction

    // out_i = XOR_k c[k] * b[(i+k) mod 8]
    function automatic logic [63:0] mix_col(input logic [63:0] col_in);
        logic [7:0]  b [8];
        logic [7:0]  acc;
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            b[i] = col_in[63-8*i -: 8];
        end
        res = 64'h0;
        for (int i = 0; i < 8; i++) begin
            acc = 8'h00;
            for (int k = 0; k < 8; k++) begin
                acc = acc ^ gf_mul_small(b[(i+k)%8], MIX_COEF[23-3*k -: 3]);
            end
            res[63-8*i -: 8] = acc;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t             state_r;
    state_t             state_nxt_s;
    logic [COL_W-1:0]   col_r;
    logic [W-1:0]       work_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               last_s;
    logic [W-1:0]       src_s;
    logic [COL_W-1:0]   base_s;
    logic [W-1:0]       merged_s;

    // Handshake decode and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        in_ready_s  = 1'b0;
        last_s      = 1'b0;

        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_DONE: in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase

        accept_s = in_valid & in_ready_s;

        if (state_r == ST_BUSY) begin
            last_s = (col_r == LAST_COL);
        end else begin
            last_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ACC_NXT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ACC_NXT;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Mix one column group: from the input bus on accept, else in place.
    always_comb begin
        if (accept_s) begin
            src_s  = in;
            base_s = {COL_W{1'b0}};
        end else begin
            src_s  = work_r;
            base_s = col_r;
        end
        merged_s = src_s;
        for (int l = 0; l < LANES; l++) begin
            merged_s[W-1-64*(int'(base_s)+l) -: 64] = mix_col(src_s[W-1-64*(int'(base_s)+l) -: 64]);
        end
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Work register and column pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_r <= {W{1'b0}};
            col_r  <= {COL_W{1'b0}};
        end else if (accept_s) begin
            work_r <= merged_s;
            col_r  <= LANE_INC;
        end else if (state_r == ST_BUSY) begin
            work_r <= merged_s;
            col_r  <= col_r + LANE_INC;
        end else begin
            work_r <= work_r;
            col_r  <= col_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out       = work_r;

endmodule

// File: tb/tb_mix_bytes_iter.sv
module tb_mix_bytes_iter;

    logic clk;
    logic reset;

    // instance A: COLS=16, LANES=4 (STEPS=4)
    logic           a_in_valid;
    logic           a_in_ready;
    logic [1023:0]  a_in;
    logic           a_out_valid;
    logic           a_out_ready;
    logic [1023:0]  a_out;
    logic           a_busy;

    // instance B: COLS=8, LANES=8 (STEPS=1)
    logic           b_in_valid;
    logic           b_in_ready;
    logic [511:0]   b_in;
    logic           b_out_valid;
    logic           b_out_ready;
    logic [511:0]   b_out;
    logic           b_busy;

    int checks;
    int failures;

    mix_bytes_iter #(.COLS(16), .LANES(4)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out),
        .busy(a_busy)
    );

    mix_bytes_iter #(.COLS(8), .LANES(8)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [63:0] ref_col(input logic [63:0] c);
        logic [7:0] cf [8];
        logic [7:0] bb [8];
        logic [7:0] acc;
        logic [63:0] r;
        cf = '{8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h05, 8'h07};
        for (int i = 0; i < 8; i++) bb[i] = c[63-8*i -: 8];
        r = 64'h0;
        for (int i = 0; i < 8; i++) begin
            acc = 8'h00;
            for (int k = 0; k < 8; k++) acc = acc ^ gmul(cf[k], bb[(i+k)%8]);
            r[63-8*i -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [1023:0] ref16(input logic [1023:0] s);
        logic [1023:0] r;
        for (int j = 0; j < 16; j++) r[1023-64*j -: 64] = ref_col(s[1023-64*j -: 64]);
        return r;
    endfunction

    function automatic logic [511:0] ref8(input logic [511:0] s);
        logic [511:0] r;
        for (int j = 0; j < 8; j++) r[511-64*j -: 64] = ref_col(s[511-64*j -: 64]);
        return r;
    endfunction

    function automatic logic [1023:0] gen16(input int seed);
        logic [1023:0] r;
        for (int j = 0; j < 16; j++)
            for (int i = 0; i < 8; i++)
                r[1023-64*j-8*i -: 8] = 8'((j*37 + i*11 + seed*73 + 5) & 255);
        return r;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            failures++;
            bad = 0;
            for (int j = 15; j >= 0; j--)
                if (obs[1023-64*j -: 64] !== exp[1023-64*j -: 64]) bad = j;
            $error("FAIL %s col=%0d observed=%h expected=%h", tag, bad,
                   obs[1023-64*bad -: 64], exp[1023-64*bad -: 64]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation on instance A with a hold-free consume.
    task automatic op_a(input string tag, input logic [1023:0] st, input logic [1023:0] exp);
        int n;
        chk({tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
        a_in = st;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        n = 1;
        while (a_out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd4);
        chk_state({tag, "_out"}, a_out, exp);
        chk({tag, "_busy"}, 64'(a_busy), 64'd1);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        chk({tag, "_consumed"}, 64'(a_out_valid), 64'd0);
    endtask

    task automatic op_b(input string tag, input logic [511:0] st, input logic [511:0] exp);
        int n;
        chk({tag, "_in_ready"}, 64'(b_in_ready), 64'd1);
        b_in = st;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        n = 1;
        while (b_out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd1);
        chk_state({tag, "_out"}, {512'd0, b_out}, {512'd0, exp});
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        chk({tag, "_consumed"}, 64'(b_out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] s1;
        logic [1023:0] r1;
        logic [1023:0] snap;
        int n;

        checks = 0;
        failures = 0;
        reset = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // reset state
        chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk_state("rst_a_out", a_out, 1024'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);

        // directed column patterns, COLS=16 LANES=4
        op_a("zero", 1024'd0, 1024'd0);
        op_a("unit", {16{64'h0100000000000000}}, {16{64'h0207050305040302}});
        op_a("msb", {16{64'h8000000000000000}}, {16{64'h1BADB69BB6369B1B}});
        op_a("ones", {16{64'h0101010101010101}}, {16{64'h0303030303030303}});
        s1 = gen16(1);
        op_a("mixed1", s1, ref16(s1));
        s1 = gen16(2);
        op_a("mixed2", s1, ref16(s1));

        // back-to-back: second state accepted in the DONE cycle of the first
        s1 = gen16(3);
        r1 = ref16(s1);
        a_out_ready = 1'b1;
        a_in = s1;
        a_in_valid = 1'b1;
        step();
        a_in = {16{64'h8000000000000000}};
        chk("b2b_busy_in_ready", 64'(a_in_ready), 64'd0);
        n = 1;
        while (a_out_valid !== 1'b1 && n < 40) begin step(); n++; end
        chk("b2b_lat1", 64'(n), 64'd4);
        chk_state("b2b_out1", a_out, r1);
        chk("b2b_done_in_ready", 64'(a_in_ready), 64'd1);
        step();
        a_in_valid = 1'b0;
        chk("b2b_gap", 64'(a_out_valid), 64'd0);
        n = 1;
        while (a_out_valid !== 1'b1 && n < 40) begin step(); n++; end
        chk("b2b_lat2", 64'(n), 64'd4);
        chk_state("b2b_out2", a_out, {16{64'h1BADB69BB6369B1B}});
        step();
        a_out_ready = 1'b0;
        chk("b2b_idle", 64'(a_busy), 64'd0);

        // hold out_ready low in DONE for 10 cycles
        s1 = gen16(4);
        r1 = ref16(s1);
        a_in = s1;
        a_in_valid = 1'b1;
        step();
        a_in = gen16(5);
        n = 1;
        while (a_out_valid !== 1'b1 && n < 40) begin step(); n++; end
        chk("hold_lat", 64'(n), 64'd4);
        snap = a_out;
        chk_state("hold_out", snap, r1);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("hold_valid", 64'(a_out_valid), 64'd1);
            chk("hold_in_ready", 64'(a_in_ready), 64'd0);
            chk_state("hold_stable", a_out, r1);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        chk("hold_once_valid", 64'(a_out_valid), 64'd0);
        chk("hold_once_in_ready", 64'(a_in_ready), 64'd1);
        step();
        chk("hold_once_valid2", 64'(a_out_valid), 64'd0);

        // reset mid-BUSY at col=8
        a_in = gen16(6);
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_in_ready", 64'(a_in_ready), 64'd1);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        chk_state("midrst_work", a_out, 1024'd0);
        repeat (5) begin
            step();
            chk("midrst_no_result", 64'(a_out_valid), 64'd0);
        end
        s1 = gen16(7);
        op_a("after_rst", s1, ref16(s1));

        // reset wins over a handshake in the same cycle
        a_in = gen16(8);
        a_in_valid = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_in_valid = 1'b0;
        step();
        chk("rst_prio_busy", 64'(a_busy), 64'd0);

        // COLS=8, LANES=8: single-step path
        op_b("b_unit", {8{64'h0100000000000000}}, {8{64'h0207050305040302}});
        op_b("b_msb", {8{64'h8000000000000000}}, {8{64'h1BADB69BB6369B1B}});
        s1 = gen16(9);
        op_b("b_mixed", s1[1023:512], ref8(s1[1023:512]));

        // COLS=8 back-to-back: one result per cycle
        b_out_ready = 1'b1;
        b_in = {8{64'h0101010101010101}};
        b_in_valid = 1'b1;
        step();
        chk("bb2b_v1", 64'(b_out_valid), 64'd1);
        chk_state("bb2b_out1", {512'd0, b_out}, {512'd0, {8{64'h0303030303030303}}});
        chk("bb2b_in_ready", 64'(b_in_ready), 64'd1);
        b_in = {8{64'h0100000000000000}};
        step();
        b_in_valid = 1'b0;
        chk("bb2b_v2", 64'(b_out_valid), 64'd1);
        chk_state("bb2b_out2", {512'd0, b_out}, {512'd0, {8{64'h0207050305040302}}});
        step();
        b_out_ready = 1'b0;
        chk("bb2b_idle", 64'(b_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
